// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: two-read, one-write register file with a hardwired-zero r[0],
// write-first bypass on both read ports and a saturating committed-write counter.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high; clears every register and wcount
//   rn1     read address, port 1
//   rn2     read address, port 2
//   wn      write address (writes to 0 are dropped)
//   we      write enable
//   wd      write data
//   rd1     read data, port 1 (combinational)
//   rd2     read data, port 2 (combinational)
//   wcount  committed writes since reset, saturates at 16'hFFFF
module reg_file_2r1w #(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned ABITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ABITS-1:0] rn1,
    input  logic [ABITS-1:0] rn2,
    input  logic [ABITS-1:0] wn,
    input  logic             we,
    input  logic [SIZE-1:0]  wd,
    output logic [SIZE-1:0]  rd1,
    output logic [SIZE-1:0]  rd2,
    output logic [15:0]      wcount
);

    logic [SIZE-1:0] r_q [DEPTH];
    logic [15:0]     wcount_q;
    logic [15:0]     wcount_d;
    logic            wr_commit;

    // A write commits only outside reset and never to register 0.
    assign wr_commit = we && !reset && (wn != '0);

    always_comb begin
        wcount_d = wcount_q;
        if (wr_commit && (wcount_q != 16'hFFFF)) begin
            wcount_d = wcount_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            wcount_q <= '0;
        end else begin
            if (wr_commit) begin
                r_q[wn] <= wd;
            end
            wcount_q <= wcount_d;
        end
    end

    // wr_commit already excludes reset and wn==0, so it doubles as the bypass qualifier.
    always_comb begin
        rd1 = '0;
        if (rn1 != '0) begin
            rd1 = (wr_commit && (wn == rn1)) ? wd : r_q[rn1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (rn2 != '0) begin
            rd2 = (wr_commit && (wn == rn2)) ? wd : r_q[rn2];
        end
    end

    assign wcount = wcount_q;

endmodule
